// File: rtl/tx_pkg.sv
// Shared definitions for the transmit stream cipher.
//   C_DATA_W          : stream word width
//   C_FRAME_LEN_W_DEF : default width of frame-length / frame-counter fields
//   tx_state_e        : framing FSM states
package tx_pkg;

  localparam int unsigned C_DATA_W          = 32;
  localparam int unsigned C_FRAME_LEN_W_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tx_state_e;

endpackage

// File: rtl/tx_stream_cipher_if.sv
// Stream bundle for the transmit cipher: plaintext input (s_axis_*) and
// framed ciphertext output (m_axis_*).
//   slave  : cipher side (consumes s_axis_*, produces m_axis_*)
//   master : source/sink side (produces s_axis_*, consumes m_axis_*)
interface tx_stream_cipher_if
  import tx_pkg::*;
();

  logic                s_axis_tvalid;
  logic                s_axis_tready;
  logic [C_DATA_W-1:0] s_axis_tdata;
  logic                m_axis_tvalid;
  logic                m_axis_tready;
  logic [C_DATA_W-1:0] m_axis_tdata;
  logic                m_axis_sof;
  logic                m_axis_eof;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_sof, m_axis_eof
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_sof, m_axis_eof
  );

endinterface

// File: rtl/prbs.sv
// 32-bit PRBS keystream generator, polynomial x^32 + x^22 + x^2 + x + 1.
//   clk, rst       : clock, synchronous active-high reset
//   i_prbs_reload  : load state from i_prbs_seed (wins over run)
//   i_prbs_seed    : seed value
//   i_prbs_run     : advance state by one step
//   o_prbs         : current keystream word (state k after reload)
module prbs (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_prbs_run,
  input  logic        i_prbs_reload,
  input  logic [31:0] i_prbs_seed,
  output logic [31:0] o_prbs
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  always_comb begin
    state_d = state_q;
    if (i_prbs_reload) begin
      state_d = i_prbs_seed;
    end else if (i_prbs_run) begin
      state_d = {state_q[30:0], state_q[31] ^ state_q[21] ^ state_q[1] ^ state_q[0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= 32'h0000_0001;
    end else begin
      state_q <= state_d;
    end
  end

  assign o_prbs = state_q;

endmodule

// File: rtl/tx_out_slice.sv
// Single-entry output register with valid/ready.
//   clk, rst   : clock, synchronous active-high reset
//   i_push     : load i_data (caller only pushes when o_in_ready)
//   i_data     : word to store
//   o_in_ready : entry free or being popped this cycle
//   o_valid    : entry occupied
//   i_ready    : downstream accepts the entry
//   o_data     : stored word, stable while o_valid && !i_ready
module tx_out_slice #(
  parameter int unsigned W = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  output logic         o_in_ready,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         valid_q;
  logic         valid_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  assign o_in_ready = !valid_q || i_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (i_push) begin
      valid_d = 1'b1;
      data_d  = i_data;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;

endmodule

// File: rtl/tx_stream_cipher.sv
// Transmit stream cipher: XORs each plaintext word with the PRBS keystream
// and emits framed ciphertext (sof/eof) through a one-entry output stage.
//   s_axi_aclk, s_axi_areset : clock, synchronous active-high reset
//   i_tx_enable              : level enable, honoured at frame boundaries
//   i_key_reload             : pulse; reload keystream from i_prbs_seed
//   i_prbs_seed              : keystream seed
//   i_frame_len              : words per frame (0 flags o_cfg_error)
//   axis                     : plaintext in / ciphertext out stream bundle
//   o_busy                   : FSM active, output occupied or reload pending
//   o_frame_count            : completed frames, wrapping
//   o_cfg_error              : enable seen with zero frame length
module tx_stream_cipher
  import tx_pkg::*;
#(
  parameter int unsigned C_FRAME_LEN_W = C_FRAME_LEN_W_DEF
) (
  input  logic                     s_axi_aclk,
  input  logic                     s_axi_areset,
  input  logic                     i_tx_enable,
  input  logic                     i_key_reload,
  input  logic [31:0]              i_prbs_seed,
  input  logic [C_FRAME_LEN_W-1:0] i_frame_len,
  tx_stream_cipher_if.slave        axis,
  output logic                     o_busy,
  output logic [C_FRAME_LEN_W-1:0] o_frame_count,
  output logic                     o_cfg_error
);

  localparam int unsigned SLICE_W = C_DATA_W + 2;

  tx_state_e                state_q, state_d;
  logic [C_FRAME_LEN_W-1:0] len_q, len_d;
  logic [C_FRAME_LEN_W-1:0] cnt_q, cnt_d;
  logic [C_FRAME_LEN_W-1:0] fc_q, fc_d;
  logic                     pend_q, pend_d;
  logic                     cfg_q, cfg_d;

  logic                i_prbs_run;
  logic                i_prbs_reload;
  logic [C_DATA_W-1:0] o_prbs;

  logic               slice_in_ready;
  logic               slice_valid;
  logic               slice_push;
  logic               s_tready;
  logic               beat_sof;
  logic               beat_eof;
  logic [SLICE_W-1:0] slice_din;
  logic [SLICE_W-1:0] slice_dout;

  prbs u_prbs (
    .clk           (s_axi_aclk),
    .rst           (s_axi_areset),
    .i_prbs_run    (i_prbs_run),
    .i_prbs_reload (i_prbs_reload),
    .i_prbs_seed   (i_prbs_seed),
    .o_prbs        (o_prbs)
  );

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    fc_d          = fc_q;
    pend_d        = pend_q | i_key_reload;
    cfg_d         = cfg_q;
    i_prbs_run    = 1'b0;
    i_prbs_reload = 1'b0;
    s_tready      = 1'b0;
    slice_push    = 1'b0;
    beat_sof      = 1'b0;
    beat_eof      = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_tx_enable && (i_frame_len == '0)) begin
          cfg_d = 1'b1;
        end
        // A pending reload blocks frame start until it has been applied, so
        // the next frame always begins at keystream state 0.
        if (pend_q) begin
          if (!slice_valid) begin
            i_prbs_reload = 1'b1;
            pend_d        = i_key_reload;
          end
        end else if (i_tx_enable && (i_frame_len != '0)) begin
          len_d   = i_frame_len;
          cnt_d   = '0;
          cfg_d   = 1'b0;
          state_d = RUN;
        end
      end

      RUN: begin
        s_tready = slice_in_ready;
        if (axis.s_axis_tvalid && s_tready) begin
          slice_push = 1'b1;
          i_prbs_run = 1'b1;
          beat_sof   = (cnt_q == '0);
          beat_eof   = (cnt_q == (len_q - C_FRAME_LEN_W'(1)));
          cnt_d      = cnt_q + C_FRAME_LEN_W'(1);
          if (beat_eof) begin
            fc_d = fc_q + C_FRAME_LEN_W'(1);
            if (i_tx_enable && !pend_q && (i_frame_len != '0)) begin
              len_d = i_frame_len;
              cnt_d = '0;
              cfg_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (!i_tx_enable) begin
      cfg_d = 1'b0;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      fc_q    <= '0;
      pend_q  <= 1'b0;
      cfg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      fc_q    <= fc_d;
      pend_q  <= pend_d;
      cfg_q   <= cfg_d;
    end
  end

  assign slice_din = {axis.s_axis_tdata ^ o_prbs, beat_sof, beat_eof};

  tx_out_slice #(
    .W (SLICE_W)
  ) u_out_slice (
    .clk        (s_axi_aclk),
    .rst        (s_axi_areset),
    .i_push     (slice_push),
    .i_data     (slice_din),
    .o_in_ready (slice_in_ready),
    .o_valid    (slice_valid),
    .i_ready    (axis.m_axis_tready),
    .o_data     (slice_dout)
  );

  assign axis.s_axis_tready = s_tready;
  assign axis.m_axis_tvalid = slice_valid;
  assign axis.m_axis_tdata  = slice_dout[SLICE_W-1:2];
  assign axis.m_axis_sof    = slice_dout[1];
  assign axis.m_axis_eof    = slice_dout[0];

  assign o_busy        = (state_q != IDLE) || slice_valid || pend_q;
  assign o_frame_count = fc_q;
  assign o_cfg_error   = cfg_q;

endmodule

// File: doc/tx_stream_cipher.md
# tx_stream_cipher

Transmit-side counterpart of the receive datapath: accepts a 32-bit plaintext AXI-Stream, XORs each word with the PRBS keystream, and emits a framed ciphertext stream with start-of-frame/end-of-frame markers. Output matches the receiver's input stream (`tdata`/`sof`/`eof`), so TX and RX loaded with the same seed recover the plaintext word for word. It sits between the plaintext source and the link, and takes its configuration from the TX register block as plain ports. Unlike the receiver, it fully honours downstream back-pressure.

## Interface
- `C_FRAME_LEN_W`, 16, width of frame-length and frame-counter fields
- `s_axi_aclk`  in  1  single clock for all logic
- `s_axi_areset`  in  1  synchronous, active-high reset
- `i_tx_enable`  in  1  transmitter enable; level
- `i_key_reload`  in  1  one-cycle pulse; request keystream reload from `i_prbs_seed`
- `i_prbs_seed`  in  32  PRBS seed
- `i_frame_len`  in  C_FRAME_LEN_W  words per frame; 0 is illegal
- `s_axis_tvalid`  in  1  plaintext valid
- `s_axis_tready`  out  1  plaintext ready
- `s_axis_tdata`  in  32  plaintext word
- `m_axis_tvalid`  out  1  ciphertext valid
- `m_axis_tready`  in  1  downstream ready
- `m_axis_tdata`  out  32  ciphertext word
- `m_axis_sof`  out  1  first word of frame
- `m_axis_eof`  out  1  last word of frame
- `o_busy`  out  1  FSM not IDLE, output stage occupied, or reload pending
- `o_frame_count`  out  C_FRAME_LEN_W  completed frames; wraps
- `o_cfg_error`  out  1  start attempted with `i_frame_len`==0

## Operation
- **Reset values:** every output is 0; FSM is IDLE; reload-pending flag is cleared; the output stage is empty.
- **Reset mid-frame:** discards the in-flight word and the partial frame. No `eof` is emitted.
- **States:**
  - IDLE:
    - If a reload is pending and the output stage is empty: pulse `i_prbs_reload` for 1 cycle, clear the pending flag, stay in IDLE.
    - Else, if `i_tx_enable` and `i_frame_len`!=0: latch `len`, clear the word counter, go to RUN.
    - `o_cfg_error` goes to 1 when `i_tx_enable`=1 and `i_frame_len`=0 in IDLE. It clears when a frame starts or `i_tx_enable`=0.
  - RUN:
    - `s_axis_tready` = (output stage empty OR `m_axis_tready`).
    - Beat accepted (`s_axis_tvalid`&&`s_axis_tready`):
      - load the output stage with `tdata ^ o_prbs`;
      - set `sof` = (counter==0) and `eof` = (counter==`len`-1);
      - drive `i_prbs_run`=1 that cycle;
      - increment the counter.
    - Last beat accepted: `o_frame_count`++ (modulo 2^C_FRAME_LEN_W).
      - If `i_tx_enable`, no reload pending, and `i_frame_len`!=0: re-latch `len`, clear the counter, stay in RUN.
      - Otherwise go to IDLE.
  - In IDLE, `s_axis_tready`=0.
- **Disable mid-frame:** the current frame completes. Disable takes effect only at the frame boundary.
- **Reload:** `i_key_reload` in RUN sets the pending flag. The reload is applied in IDLE after the frame ends. Reload in IDLE is applied once the output stage drains.
- **Frame length:** changes to `i_frame_len` during a frame are ignored until the next frame start.
- **Frame length 1:** `sof` and `eof` are both asserted on the same word.
- **Keystream alignment:** word k after a reload is XORed with PRBS state k; state 0 is the value immediately following reload. This matches the receiver.

## Timing
- Latency: word accepted at edge N → `m_axis_tvalid`=1 with its ciphertext after edge N.
- Throughput: 1 word/cycle while `m_axis_tready`=1.
- Output handshake: `m_axis_tdata`/`sof`/`eof` are held stable while `tvalid`&&!`tready`.
- Output stage load:
  - when empty, or on a simultaneous pop and push, it loads the new word;
  - on a pop with no push, it goes empty.
- `s_axis_tready` depends combinationally on `m_axis_tready`. There is no combinational path from `s_axis_tvalid` to `m_axis_*`.
- PRBS advances exactly once per accepted word. A stalled cycle never advances it.
- IDLE→RUN costs 1 cycle. Frame-to-frame in RUN costs 0 cycles.

## Structure
- Package `tx_pkg`: state enum (IDLE, RUN), `C_FRAME_LEN_W` default, data width constant 32.
- Reuse the existing `prbs` module as an instance, driving `i_prbs_run`, `i_prbs_reload` (internal pulse), `i_prbs_seed`, and `o_prbs`.
- One natural sub-module: `tx_out_slice`, a single-entry output register carrying {tdata, sof, eof} with valid/ready.

## Test plan
- **Basic frame:** seed 0x00000001, len 4, plaintext 0x0,0x1,0x2,0x3, `m_axis_tready`=1 → 4 words equal to plaintext ^ PRBS states 0..3; `sof` on word 0 only; `eof` on word 3 only; `o_frame_count`=1.
- **Loopback:** TX output feeds RX, same seed, len 8, random data → RX output equals the plaintext.
- **Back-pressure:** `m_axis_tready` low for 3 cycles mid-frame → output word held stable; `s_axis_tready`=0 while the stage is full; the PRBS does not advance; the sequence is unchanged afterwards.
- **Edge cases:** len=1 → every word has `sof`=`eof`=1. len=0 with enable → `o_cfg_error`=1 and `s_axis_tready`=0.
- **Reload mid-frame:** reload pulse at word 2 of len 4 → frame finishes on the old keystream; the next frame starts again from PRBS state 0.
- **Disable and wrap:**
  - disable at word 1 of len 4 → words 2 and 3 are still sent, then IDLE;
  - `o_frame_count` at 0xFFFF plus one frame → 0x0000.
